bus_xfer_ctrl: RTL

//  Responder-side bus transfer controller. Directly upstream of the req->ack->done

---
 rtl/bus_xfer_pkg.sv | 11 +
 rtl/bus_xfer_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_pkg.sv
// Shared types and constants for the responder-side bus transfer controller.
//   xfer_state_e  : controller FSM states
//   MAX_ACK2DONE  : largest bus_ack -> done distance the downstream
//                   req/ack/done checker accepts
package bus_xfer_pkg;

  typedef enum logic [2:0] {IDLE, ACK, XFER, WAIT, DONE} xfer_state_e;

  localparam int MAX_ACK2DONE = 5;

endpackage

// File: rtl/bus_xfer_ctrl.sv
// Responder-side bus transfer controller.
// On each rising bus_req it acknowledges, optionally streams a burst of
// 1..MAX_BEATS beats, and completes with a one-cycle done pulse.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous active-high reset
//   bus_req           request; only a 0->1 edge starts a transfer
//   xfer_len          beat count, captured when the request edge is accepted
//   data_in           beat data, captured on every envelope cycle
//   bus_ack           one-cycle acknowledge
//   ready             one-cycle burst-start marker, coincident with bus_ack
//   transfer_envelope high for every beat cycle
//   done              one-cycle completion pulse
//   err               one-cycle error pulse (busy request or oversize length)
//   data_out          registered copy of data_in per beat
//   beat_cnt          beats completed in the current transfer
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int MAX_BEATS  = 5,
  parameter int LEN_W      = 3,
  parameter int DATA_W     = 8,
  parameter int NODATA_DLY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  input  logic [LEN_W-1:0]  xfer_len,
  input  logic [DATA_W-1:0] data_in,
  output logic              bus_ack,
  output logic              ready,
  output logic              transfer_envelope,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] data_out,
  output logic [LEN_W-1:0]  beat_cnt
);

  // Keep done within MAX_ACK2DONE cycles of bus_ack for any legal setting.
  if (MAX_BEATS < 1 || MAX_BEATS > MAX_ACK2DONE) begin : g_chk_max_beats
    $error("bus_xfer_ctrl: MAX_BEATS=%0d outside 1..%0d", MAX_BEATS, MAX_ACK2DONE);
  end
  if (NODATA_DLY < 1 || NODATA_DLY > MAX_ACK2DONE) begin : g_chk_nodata_dly
    $error("bus_xfer_ctrl: NODATA_DLY=%0d outside 1..%0d", NODATA_DLY, MAX_ACK2DONE);
  end
  if ((1 << LEN_W) <= MAX_BEATS) begin : g_chk_len_w
    $error("bus_xfer_ctrl: LEN_W=%0d cannot hold MAX_BEATS=%0d", LEN_W, MAX_BEATS);
  end

  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_BEATS);
  // ACK already accounts for one of the NODATA_DLY cycles, WAIT covers the rest.
  localparam logic [2:0]       WAIT_LAST = 3'((NODATA_DLY > 1) ? NODATA_DLY - 2 : 0);

  xfer_state_e      state, state_next;
  logic             bus_req_d;
  logic             rise;
  logic             accept;
  logic             pend, pend_next;
  logic [LEN_W-1:0] len, len_next;
  logic             len_bad, len_bad_next;
  logic [2:0]       wait_cnt, wait_cnt_next;
  logic             busy_err;
  logic             has_data, has_data_next;
  logic [LEN_W-1:0] beats_after;
  logic             more_beats;

  assign rise          = bus_req & ~bus_req_d;
  // A rise is taken in IDLE, and also in DONE where it is parked in pend.
  assign accept        = rise && (state == IDLE || state == DONE);
  assign has_data      = (len != '0) && !len_bad;
  assign has_data_next = (len_next != '0) && !len_bad_next;
  // Beats completed once the current envelope cycle ends.
  assign beats_after   = beat_cnt + LEN_W'(1);
  assign more_beats    = beats_after < len;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_next    = state;
    pend_next     = 1'b0;
    len_next      = len;
    len_bad_next  = len_bad;
    wait_cnt_next = wait_cnt;
    busy_err      = 1'b0;

    if (accept) begin
      len_next     = xfer_len;
      len_bad_next = (xfer_len > LEN_MAX);
    end

    unique case (state)
      IDLE: begin
        if (rise || pend) state_next = ACK;
      end
      ACK: begin
        busy_err = rise;
        if (has_data) begin
          state_next = more_beats ? XFER : DONE;
        end else if (NODATA_DLY > 1) begin
          state_next    = WAIT;
          wait_cnt_next = '0;
        end else begin
          state_next = DONE;
        end
      end
      XFER: begin
        busy_err   = rise;
        state_next = more_beats ? XFER : DONE;
      end
      WAIT: begin
        busy_err = rise;
        if (wait_cnt == WAIT_LAST) state_next = DONE;
        else                       wait_cnt_next = wait_cnt + 3'd1;
      end
      DONE: begin
        state_next = IDLE;
        pend_next  = rise;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is glitch-free
  // and lines up with the state it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      bus_req_d         <= 1'b1;  // a request held through reset is not a rise
      pend              <= 1'b0;
      len               <= '0;
      len_bad           <= 1'b0;
      wait_cnt          <= '0;
      bus_ack           <= 1'b0;
      ready             <= 1'b0;
      transfer_envelope <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      data_out          <= '0;
      beat_cnt          <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge values, independent of statement order.
      state             <= state_next;
      bus_req_d         <= bus_req;
      pend              <= pend_next;
      len               <= len_next;
      len_bad           <= len_bad_next;
      wait_cnt          <= wait_cnt_next;
      bus_ack           <= (state_next == ACK);
      ready             <= (state_next == ACK) && has_data_next;
      transfer_envelope <= ((state_next == ACK) && has_data_next) || (state_next == XFER);
      done              <= (state_next == DONE);
      err               <= busy_err || ((state_next == DONE) && len_bad_next);
      if (transfer_envelope) begin
        data_out <= data_in;
        beat_cnt <= beats_after;
      end else if (state_next == IDLE) begin
        beat_cnt <= '0;
      end
    end
  end

endmodule
